// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared state type and sizing constants for the memory responder
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } stateT;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_BYTE_WIDTH = 8;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / DEFAULT_BYTE_WIDTH;
    localparam int COUNT_WIDTH        = 4;

endpackage

// File: rtl/mem_byte_array.sv
// rtl/mem_byte_array.sv - word-indexed backing store, per-lane write port, registered read port
module mem_byte_array
    import mem_resp_pkg::*;
#(
    parameter int INDEX_WIDTH = 15,
    parameter int BYTE_WIDTH  = DEFAULT_BYTE_WIDTH,
    parameter int LANES       = BYTES_PER_WORD
) (
    input  logic                          CLK,
    input  logic                          wrEn,
    input  logic [LANES-1:0]              wrLaneEn,
    input  logic [INDEX_WIDTH-1:0]        wrIndex,
    input  logic [LANES*BYTE_WIDTH-1:0]   wrData,
    input  logic [INDEX_WIDTH-1:0]        rdIndex,
    output logic [LANES*BYTE_WIDTH-1:0]   rdData
);

    logic [LANES*BYTE_WIDTH-1:0] mem [0:(1<<INDEX_WIDTH)-1];

    // Contents are deliberately never reset.
    always_ff @(posedge CLK) begin
        if (wrEn) begin
            for (int l = 0; l < LANES; l++) begin
                if (wrLaneEn[l]) begin
                    mem[wrIndex][l*BYTE_WIDTH +: BYTE_WIDTH] <= wrData[l*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        rdData <= mem[rdIndex];
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - latency-modelling memory responder behind the data cache
// Optional MEM_MISALIGN_ERR_EN adds rsp_err and rejects accesses with addr[1:0] != 0.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = 17,
    parameter int BYTE_WIDTH    = DEFAULT_BYTE_WIDTH,
    parameter int LATENCY       = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_be,
    input  logic [ADDRESS_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
`ifdef MEM_MISALIGN_ERR_EN
    output logic                             rsp_err,
`endif
    output logic                             busy
);

    localparam int LANES       = DATA_WIDTH / BYTE_WIDTH;
    localparam int INDEX_WIDTH = ADDRESS_WIDTH - 2;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(LATENCY - 1);

    stateT                  state;
    stateT                  stateNext;
    logic [COUNT_WIDTH-1:0] count;
    logic                   weQ;
    logic [LANES-1:0]       beQ;
    logic [INDEX_WIDTH-1:0] indexQ;
    logic [DATA_WIDTH-1:0]  wdataQ;
    logic                   misalignQ;
    logic                   reqMisaligned;
    logic                   accept;
    logic                   complete;
    logic                   wrEn;
    logic [INDEX_WIDTH-1:0] rdIndex;
    logic [DATA_WIDTH-1:0]  rdWord;
    logic [DATA_WIDTH-1:0]  mergedWord;
    logic [DATA_WIDTH-1:0]  resultWord;

`ifdef MEM_MISALIGN_ERR_EN
    logic rspErrQ;
    assign reqMisaligned = |req_addr[1:0];
    assign rsp_err       = rspErrQ;
`else
    logic unusedAddrBits;
    assign reqMisaligned  = 1'b0;
    assign unusedAddrBits = ^req_addr[1:0];
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign accept   = req_valid & req_ready;
    assign complete = (state == BUSY) && (count == '0);
    // A reset landing on the completion edge must abandon the write.
    assign wrEn     = complete & weQ & ~misalignQ & RST;

    // While idle, prefetch the word at the incoming address so it is ready by the completion edge.
    assign rdIndex = (state == IDLE) ? req_addr[ADDRESS_WIDTH-1:2] : indexQ;

    always_comb begin
        mergedWord = rdWord;
        for (int l = 0; l < LANES; l++) begin
            if (beQ[l]) begin
                mergedWord[l*BYTE_WIDTH +: BYTE_WIDTH] = wdataQ[l*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        resultWord = misalignQ ? '0 : (weQ ? mergedWord : rdWord);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            count     <= '0;
            weQ       <= 1'b0;
            beQ       <= '0;
            indexQ    <= '0;
            wdataQ    <= '0;
            misalignQ <= 1'b0;
            rsp_rdata <= '0;
`ifdef MEM_MISALIGN_ERR_EN
            rspErrQ   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                weQ       <= req_we;
                beQ       <= req_be;
                indexQ    <= req_addr[ADDRESS_WIDTH-1:2];
                wdataQ    <= req_wdata;
                misalignQ <= reqMisaligned;
                count     <= COUNT_LOAD;
            end else if ((state == BUSY) && (count != '0)) begin
                count <= count - 1'b1;
            end
            if (complete) begin
                rsp_rdata <= resultWord;
`ifdef MEM_MISALIGN_ERR_EN
                rspErrQ   <= misalignQ;
`endif
            end
        end
    end

    mem_byte_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .BYTE_WIDTH  (BYTE_WIDTH),
        .LANES       (LANES)
    ) u_array (
        .CLK      (CLK),
        .wrEn     (wrEn),
        .wrLaneEn (beQ),
        .wrIndex  (indexQ),
        .wrData   (wdataQ),
        .rdIndex  (rdIndex),
        .rdData   (rdWord)
    );

endmodule
